// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline: req/ack data-memory access with byte-lane
// alignment, upstream stall and the MEM/WB register.
// Optional ack watchdog: define DMEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nop,
  input  logic [31:0] ALU_co_pype,
  input  logic [31:0] read_data2_pype2,
  input  logic [4:0]  WReg_pype2,
  input  logic        RegWrite_pype2,
  input  logic [1:0]  MemtoReg_pype2,
  input  logic [1:0]  MemRW_pype2,
  input  logic [31:0] PCp4_pype2,
  input  logic [31:0] Instraction_pype2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        keep_mem,
  output logic        mem_err,
  output logic [31:0] MemData_pype3,
  output logic [31:0] ALU_co_pype3,
  output logic [31:0] PCp4_pype3,
  output logic [4:0]  WReg_pype3,
  output logic        RegWrite_pype3,
  output logic [1:0]  MemtoReg_pype3,
  output logic [31:0] Instraction_pype3
);

  typedef enum logic {IDLE, REQ} state_e;
  typedef enum logic [1:0] {WB_BUBBLE, WB_PASS, WB_MEM} wb_sel_e;

  state_e  state_q, state_d;
  wb_sel_e wb_sel;

  logic capture;
  logic err_d, err_q;
  logic timeout;

  // ---------------------------------------------------------------------------
  // Decode of the instruction at the MEM input
  // ---------------------------------------------------------------------------
  logic [1:0] size;
  logic       is_load, is_store, is_mem;
  logic       misaligned, mem_op, err_misaligned;

  assign size     = Instraction_pype2[13:12];
  assign is_load  = (MemRW_pype2 == 2'b01);
  assign is_store = (MemRW_pype2 == 2'b10);
  assign is_mem   = is_load | is_store;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ALU_co_pype[0];
      default: misaligned = |ALU_co_pype[1:0];
    endcase
  end

  assign mem_op         = is_mem & ~misaligned & ~nop;
  assign err_misaligned = is_mem &  misaligned & ~nop;

  // Store lane steering; loads always fetch the whole word
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = read_data2_pype2;
    case (size)
      2'b00: begin
        st_be    = 4'b0001 << ALU_co_pype[1:0];
        st_wdata = {4{read_data2_pype2[7:0]}};
      end
      2'b01: begin
        st_be    = ALU_co_pype[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{read_data2_pype2[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access registers: the bus request and the instruction fields are captured
  // on entry to REQ so the access stays stable and cannot be cancelled.
  // ---------------------------------------------------------------------------
  logic [31:0] acc_addr_q;
  logic [3:0]  acc_be_q;
  logic [31:0] acc_wdata_q;
  logic        acc_we_q;
  logic [31:0] acc_pcp4_q;
  logic [31:0] acc_instr_q;
  logic [4:0]  acc_wreg_q;
  logic        acc_regwrite_q;
  logic [1:0]  acc_memtoreg_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_addr_q     <= '0;
      acc_be_q       <= '0;
      acc_wdata_q    <= '0;
      acc_we_q       <= 1'b0;
      acc_pcp4_q     <= '0;
      acc_instr_q    <= '0;
      acc_wreg_q     <= '0;
      acc_regwrite_q <= 1'b0;
      acc_memtoreg_q <= '0;
    end else if (capture) begin
      acc_addr_q     <= ALU_co_pype;
      acc_be_q       <= is_store ? st_be : 4'b1111;
      acc_wdata_q    <= is_store ? st_wdata : '0;
      acc_we_q       <= is_store;
      acc_pcp4_q     <= PCp4_pype2;
      acc_instr_q    <= Instraction_pype2;
      acc_wreg_q     <= WReg_pype2;
      acc_regwrite_q <= RegWrite_pype2;
      acc_memtoreg_q <= MemtoReg_pype2;
    end
  end

  assign dmem_we    = acc_we_q;
  assign dmem_addr  = {acc_addr_q[31:2], 2'b00};
  assign dmem_be    = acc_be_q;
  assign dmem_wdata = acc_wdata_q;

  // ---------------------------------------------------------------------------
  // Ack watchdog
  // ---------------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Zero while idle, so the count restarts on every entry to REQ
  assign cnt_d   = (state_q == REQ) ? cnt_q + CntW'(1) : '0;
  assign timeout = (state_q == REQ) && !dmem_ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = REQ;
      REQ:     if (dmem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    keep_mem = 1'b0;
    capture  = 1'b0;
    err_d    = 1'b0;
    wb_sel   = WB_BUBBLE;
    case (state_q)
      IDLE: begin
        capture  = mem_op;
        keep_mem = mem_op;
        err_d    = err_misaligned;
        if (!nop && !is_mem) wb_sel = WB_PASS;
      end
      REQ: begin
        dmem_req = 1'b1;
        // A timed-out access releases the stall so the faulting op is dropped
        keep_mem = !(dmem_ack || timeout);
        err_d    = timeout;
        if (dmem_ack) wb_sel = WB_MEM;
      end
      default: ;
    endcase
  end

  assign mem_err = err_q;

  // ---------------------------------------------------------------------------
  // Load data extraction
  // ---------------------------------------------------------------------------
  logic [31:0] ld_shift, ld_data;

  assign ld_shift = dmem_rdata >> {acc_addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = dmem_rdata;
    case (acc_instr_q[14:12])
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'b0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  logic [31:0] memdata_d, alu_d, pcp4_d, instr_d;
  logic [4:0]  wreg_d;
  logic        regwrite_d;
  logic [1:0]  memtoreg_d;

  always_comb begin
    memdata_d  = '0;
    alu_d      = '0;
    pcp4_d     = '0;
    instr_d    = '0;
    wreg_d     = '0;
    regwrite_d = 1'b0;
    memtoreg_d = '0;
    case (wb_sel)
      WB_PASS: begin
        alu_d      = ALU_co_pype;
        pcp4_d     = PCp4_pype2;
        instr_d    = Instraction_pype2;
        wreg_d     = WReg_pype2;
        regwrite_d = RegWrite_pype2;
        memtoreg_d = MemtoReg_pype2;
      end
      WB_MEM: begin
        memdata_d  = acc_we_q ? 32'b0 : ld_data;
        alu_d      = acc_addr_q;
        pcp4_d     = acc_pcp4_q;
        instr_d    = acc_instr_q;
        wreg_d     = acc_wreg_q;
        regwrite_d = acc_regwrite_q;
        memtoreg_d = acc_memtoreg_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemData_pype3     <= '0;
      ALU_co_pype3      <= '0;
      PCp4_pype3        <= '0;
      Instraction_pype3 <= '0;
      WReg_pype3        <= '0;
      RegWrite_pype3    <= 1'b0;
      MemtoReg_pype3    <= '0;
    end else begin
      MemData_pype3     <= memdata_d;
      ALU_co_pype3      <= alu_d;
      PCp4_pype3        <= pcp4_d;
      Instraction_pype3 <= instr_d;
      WReg_pype3        <= wreg_d;
      RegWrite_pype3    <= regwrite_d;
      MemtoReg_pype3    <= memtoreg_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops
// checked against a byte-level reference model of the load/store rules.
`timescale 1ns/1ps
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        nop;
  logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2, Instraction_pype2;
  logic [4:0]  WReg_pype2;
  logic        RegWrite_pype2;
  logic [1:0]  MemtoReg_pype2, MemRW_pype2;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        keep_mem, mem_err;
  logic [31:0] MemData_pype3, ALU_co_pype3, PCp4_pype3, Instraction_pype3;
  logic [4:0]  WReg_pype3;
  logic        RegWrite_pype3;
  logic [1:0]  MemtoReg_pype3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .nop(nop),
    .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
    .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2),
    .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
    .PCp4_pype2(PCp4_pype2), .Instraction_pype2(Instraction_pype2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .keep_mem(keep_mem), .mem_err(mem_err),
    .MemData_pype3(MemData_pype3), .ALU_co_pype3(ALU_co_pype3),
    .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
    .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
    .Instraction_pype3(Instraction_pype3)
  );

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int unsigned op_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % op_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a, input bit st);
    int unsigned n, off;
    n   = op_bytes(f3);
    off = a % 4;
    if (!st) return 4'hF;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int unsigned n;
    n = op_bytes(f3);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int unsigned n;
    longint v;
    n = op_bytes(f3);
    if (n == 4) return rdata;
    v = longint'(rdata >> (8 * (a % 4)));
    v = v % (64'd1 << (8 * n));
    if (!f3[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- stimulus drivers ----------------
  task automatic set_idle();
    nop = 1'b0; ALU_co_pype = '0; read_data2_pype2 = '0; WReg_pype2 = '0;
    RegWrite_pype2 = 1'b0; MemtoReg_pype2 = '0; MemRW_pype2 = '0;
    PCp4_pype2 = '0; Instraction_pype2 = '0;
  endtask

  task automatic set_op(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd, input logic regw);
    logic [31:0] ins;
    ins = $urandom();
    ins[14:12] = f3;
    nop = 1'b0; MemRW_pype2 = rw; ALU_co_pype = a; read_data2_pype2 = d;
    WReg_pype2 = rd; RegWrite_pype2 = regw; MemtoReg_pype2 = 2'($urandom_range(0, 3));
    PCp4_pype2 = $urandom(); Instraction_pype2 = ins;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset dmem_req: got %b want 0", dmem_req); end
    n_checks++; if (keep_mem !== 1'b0) begin n_fail++; $display("FAIL reset keep_mem: got %b want 0", keep_mem); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset mem_err: got %b want 0", mem_err); end
    n_checks++; if ({MemData_pype3, ALU_co_pype3, PCp4_pype3, Instraction_pype3} !== 128'b0) begin n_fail++; $display("FAIL reset pype3_words: got %h want 0", {MemData_pype3, ALU_co_pype3, PCp4_pype3, Instraction_pype3}); end
    n_checks++; if ({WReg_pype3, RegWrite_pype3, MemtoReg_pype3} !== 8'b0) begin n_fail++; $display("FAIL reset pype3_ctrl: got %h want 0", {WReg_pype3, RegWrite_pype3, MemtoReg_pype3}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu_op();
    @(negedge clk);
    set_op(2'b00, 3'b000, 32'h0000_0005, 32'h0, 5'd3, 1'b1);
    #1;
    n_checks++; if (keep_mem !== 1'b0) begin n_fail++; $display("FAIL alu keep_mem: got %b want 0", keep_mem); end
    @(negedge clk);
    n_checks++; if (ALU_co_pype3 !== 32'h5) begin n_fail++; $display("FAIL alu result: got %h want 5", ALU_co_pype3); end
    n_checks++; if (WReg_pype3 !== 5'd3) begin n_fail++; $display("FAIL alu rd: got %0d want 3", WReg_pype3); end
    n_checks++; if (RegWrite_pype3 !== 1'b1) begin n_fail++; $display("FAIL alu regwrite: got %b want 1", RegWrite_pype3); end
    n_checks++; if (MemData_pype3 !== 32'h0) begin n_fail++; $display("FAIL alu memdata: got %h want 0", MemData_pype3); end
    n_checks++; if (Instraction_pype3 !== Instraction_pype2) begin n_fail++; $display("FAIL alu instr: got %h want %h", Instraction_pype3, Instraction_pype2); end
    n_checks++; if (keep_mem !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu no_stall: got keep=%b req=%b want 0/0", keep_mem, dmem_req); end
    set_idle();
  endtask

  task automatic test_load_byte();
    @(negedge clk);
    set_op(2'b01, 3'b000, 32'h0000_0103, 32'h0, 5'd9, 1'b1);
    #1;
    n_checks++; if (keep_mem !== 1'b1) begin n_fail++; $display("FAIL lb keep_idle: got %b want 1", keep_mem); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lb req_idle: got %b want 0", dmem_req); end
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL lb req: got %b want 1", dmem_req); end
    n_checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'hF || dmem_we !== 1'b0) begin n_fail++; $display("FAIL lb bus: got addr=%h be=%b we=%b want 100/1111/0", dmem_addr, dmem_be, dmem_we); end
    dmem_ack = 1'b1; dmem_rdata = 32'h80AB_CDEF;
    #1;
    n_checks++; if (keep_mem !== 1'b0) begin n_fail++; $display("FAIL lb keep_ack: got %b want 0", keep_mem); end
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    n_checks++; if (MemData_pype3 !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb data: got %h want ffffff80", MemData_pype3); end
    n_checks++; if (RegWrite_pype3 !== 1'b1 || WReg_pype3 !== 5'd9) begin n_fail++; $display("FAIL lb wb: got rw=%b rd=%0d want 1/9", RegWrite_pype3, WReg_pype3); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lb req_done: got %b want 0", dmem_req); end
    set_idle();
  endtask

  task automatic test_load_wait();
    @(negedge clk);
    set_op(2'b01, 3'b101, 32'h0000_0102, 32'h0, 5'd12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_rdata = $urandom();
      #1;
      n_checks++; if (keep_mem !== 1'b1 || dmem_req !== 1'b1) begin n_fail++; $display("FAIL lhu wait%0d: got keep=%b req=%b want 1/1", i, keep_mem, dmem_req); end
      n_checks++; if (RegWrite_pype3 !== 1'b0) begin n_fail++; $display("FAIL lhu bubble%0d: got %b want 0", i, RegWrite_pype3); end
    end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h9234_5678;
    #1;
    n_checks++; if (keep_mem !== 1'b0) begin n_fail++; $display("FAIL lhu keep_ack: got %b want 0", keep_mem); end
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++; if (MemData_pype3 !== 32'h0000_9234) begin n_fail++; $display("FAIL lhu data: got %h want 00009234", MemData_pype3); end
    n_checks++; if (RegWrite_pype3 !== 1'b1) begin n_fail++; $display("FAIL lhu regwrite: got %b want 1", RegWrite_pype3); end
    set_idle();
  endtask

  task automatic test_store();
    @(negedge clk);
    set_op(2'b10, 3'b000, 32'h0000_0201, 32'h0000_00A5, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL sb we: got %b want 1", dmem_we); end
    n_checks++; if (dmem_be !== 4'b0010) begin n_fail++; $display("FAIL sb be: got %b want 0010", dmem_be); end
    n_checks++; if (dmem_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb wdata: got %h want a5a5a5a5", dmem_wdata); end
    n_checks++; if (dmem_addr !== 32'h200) begin n_fail++; $display("FAIL sb addr: got %h want 200", dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++; if (MemData_pype3 !== 32'h0 || ALU_co_pype3 !== 32'h201) begin n_fail++; $display("FAIL sb wb: got data=%h alu=%h want 0/201", MemData_pype3, ALU_co_pype3); end
    set_idle();
  endtask

  task automatic test_misaligned();
    logic [1:0]  rws [2] = '{2'b01, 2'b10};
    logic [2:0]  f3s [2] = '{3'b010, 3'b001};
    logic [31:0] ads [2] = '{32'h102, 32'h203};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_op(rws[i], f3s[i], ads[i], 32'h1234_5678, 5'd5, 1'b1);
      #1;
      n_checks++; if (keep_mem !== 1'b0) begin n_fail++; $display("FAIL misal%0d keep: got %b want 0", i, keep_mem); end
      @(negedge clk);
      n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL misal%0d err: got %b want 1", i, mem_err); end
      n_checks++; if (dmem_req !== 1'b0 || RegWrite_pype3 !== 1'b0) begin n_fail++; $display("FAIL misal%0d bubble: got req=%b rw=%b want 0/0", i, dmem_req, RegWrite_pype3); end
      set_idle();
      @(negedge clk);
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL misal%0d err_pulse: got %b want 0", i, mem_err); end
    end
  endtask

  task automatic test_nop();
    @(negedge clk);
    set_op(2'b01, 3'b010, 32'h0000_0300, 32'h0, 5'd4, 1'b1);
    nop = 1'b1;
    #1;
    n_checks++; if (keep_mem !== 1'b0) begin n_fail++; $display("FAIL nop keep: got %b want 0", keep_mem); end
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b0 || RegWrite_pype3 !== 1'b0 || ALU_co_pype3 !== 32'h0) begin n_fail++; $display("FAIL nop bubble: got req=%b rw=%b alu=%h want 0", dmem_req, RegWrite_pype3, ALU_co_pype3); end
    // A flush arriving once the access is on the bus must not cancel it
    nop = 1'b0;
    @(negedge clk);
    nop = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++; if (MemData_pype3 !== 32'h0BAD_F00D || RegWrite_pype3 !== 1'b1) begin n_fail++; $display("FAIL nop_in_req: got data=%h rw=%b want 0badf00d/1", MemData_pype3, RegWrite_pype3); end
    set_idle();
  endtask

  task automatic test_wait_limit();
    @(negedge clk);
    set_op(2'b01, 3'b010, 32'h0000_0400, 32'h0, 5'd7, 1'b1);
`ifdef DMEM_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      #1;
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL timeout req%0d: got %b want 1", i, dmem_req); end
      n_checks++; if (keep_mem !== (i != int'(TO) - 1)) begin n_fail++; $display("FAIL timeout keep%0d: got %b want %b", i, keep_mem, i != int'(TO) - 1); end
    end
    @(negedge clk);
    set_idle();
    #1;
    n_checks++; if (dmem_req !== 1'b0 || mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout end: got req=%b err=%b want 0/1", dmem_req, mem_err); end
    n_checks++; if (keep_mem !== 1'b0 || RegWrite_pype3 !== 1'b0) begin n_fail++; $display("FAIL timeout wb: got keep=%b rw=%b want 0/0", keep_mem, RegWrite_pype3); end
    @(negedge clk);
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL timeout err_pulse: got %b want 0", mem_err); end
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_checks++; if (dmem_req !== 1'b1 || keep_mem !== 1'b1 || mem_err !== 1'b0) begin n_fail++; $display("FAIL longwait%0d: got req=%b keep=%b err=%b want 1/1/0", i, dmem_req, keep_mem, mem_err); end
    end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++; if (MemData_pype3 !== 32'h1234_5678) begin n_fail++; $display("FAIL longwait data: got %h want 12345678", MemData_pype3); end
    set_idle();
`endif
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    set_op(2'b01, 3'b010, 32'h0000_0500, 32'h0, 5'd8, 1'b1);
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid req_before: got %b want 1", dmem_req); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid req: got %b want 0", dmem_req); end
    n_checks++; if (MemData_pype3 !== 32'h0 || ALU_co_pype3 !== 32'h0 || RegWrite_pype3 !== 1'b0) begin n_fail++; $display("FAIL rstmid outs: got data=%h alu=%h rw=%b want 0", MemData_pype3, ALU_co_pype3, RegWrite_pype3); end
    @(negedge clk);
    set_op(2'b00, 3'b000, 32'h0000_0077, 32'h0, 5'd2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_checks++; if (MemData_pype3 !== 32'h0 || ALU_co_pype3 !== 32'h77) begin n_fail++; $display("FAIL rstmid stray_ack: got data=%h alu=%h want 0/77", MemData_pype3, ALU_co_pype3); end
    n_checks++; if (dmem_req !== 1'b0 || mem_err !== 1'b0) begin n_fail++; $display("FAIL rstmid idle: got req=%b err=%b want 0/0", dmem_req, mem_err); end
    set_idle();
  endtask

  task automatic test_random();
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  rw;
      logic [2:0]  f3;
      logic [31:0] a, d, ack_word;
      logic        kill, is_mem, mis, valid, is_st, pass;
      int unsigned wait_n;
      rw = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      d  = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      kill   = ($urandom_range(0, 7) == 0);
      is_mem = (rw == 2'b01) || (rw == 2'b10);
      is_st  = (rw == 2'b10);
      mis    = is_mem && model_misaligned(f3, a);
      valid  = is_mem && !mis && !kill;
      pass   = !kill && !mis;
      wait_n = $urandom_range(0, 3);
      ack_word = '0;
      set_op(rw, f3, a, d, 5'($urandom()), 1'($urandom()));
      nop = kill;
      #1;
      n_checks++; if (keep_mem !== valid || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rnd%0d issue: got keep=%b req=%b want %b/0", i, keep_mem, dmem_req, valid); end
      if (valid) begin
        for (int w = 0; w <= int'(wait_n); w++) begin
          @(negedge clk);
          n_checks++; if (dmem_req !== 1'b1 || dmem_we !== is_st || dmem_addr !== a - (a % 4) || dmem_be !== model_be(f3, a, is_st)) begin n_fail++; $display("FAIL rnd%0d bus: got req=%b we=%b addr=%h be=%b want 1/%b/%h/%b", i, dmem_req, dmem_we, dmem_addr, dmem_be, is_st, a - (a % 4), model_be(f3, a, is_st)); end
          if (is_st) begin
            n_checks++; if (dmem_wdata !== model_wdata(f3, d)) begin n_fail++; $display("FAIL rnd%0d wdata: got %h want %h", i, dmem_wdata, model_wdata(f3, d)); end
          end
          ack_word = $urandom();
          dmem_rdata = ack_word;
          dmem_ack = (w == int'(wait_n));
          #1;
          n_checks++; if (keep_mem !== (w != int'(wait_n))) begin n_fail++; $display("FAIL rnd%0d keep_req: got %b want %b", i, keep_mem, w != int'(wait_n)); end
        end
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = $urandom();
      n_checks++; if (MemData_pype3 !== ((valid && !is_st) ? model_load(f3, a, ack_word) : 32'h0)) begin n_fail++; $display("FAIL rnd%0d memdata: got %h want %h", i, MemData_pype3, (valid && !is_st) ? model_load(f3, a, ack_word) : 32'h0); end
      n_checks++; if (ALU_co_pype3 !== (pass ? a : 32'h0) || PCp4_pype3 !== (pass ? PCp4_pype2 : 32'h0) || Instraction_pype3 !== (pass ? Instraction_pype2 : 32'h0)) begin n_fail++; $display("FAIL rnd%0d words: got alu=%h pc=%h ins=%h", i, ALU_co_pype3, PCp4_pype3, Instraction_pype3); end
      n_checks++; if (WReg_pype3 !== (pass ? WReg_pype2 : 5'd0) || RegWrite_pype3 !== (pass ? RegWrite_pype2 : 1'b0) || MemtoReg_pype3 !== (pass ? MemtoReg_pype2 : 2'd0)) begin n_fail++; $display("FAIL rnd%0d ctrl: got rd=%0d rw=%b m2r=%0d", i, WReg_pype3, RegWrite_pype3, MemtoReg_pype3); end
      n_checks++; if (mem_err !== (mis && !kill) || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rnd%0d err: got err=%b req=%b want %b/0", i, mem_err, dmem_req, mis && !kill); end
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    set_idle();
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    test_reset();
    test_alu_op();
    test_load_byte();
    test_load_wait();
    test_store();
    test_misaligned();
    test_nop();
    test_wait_limit();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RV32I pipeline. It sits downstream of the EX/MEM register and consumes the ALU address/result, store data, control and instruction fields produced by the execute stage.
- Drives a req/ack data-memory bus for loads and stores, with byte-lane alignment on both paths.
- Stalls upstream stages while an access is outstanding.
- Produces the MEM/WB pipeline register, including sign- or zero-extended load data.

Parameters:
- TIMEOUT_CYCLES, 64, watchdog limit in cycles waiting for dmem_ack (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- nop  in  1  flush: the instruction at the MEM input becomes a bubble
- ALU_co_pype  in  32  ALU result; the effective address for memory ops
- read_data2_pype2  in  32  store data (LSBs valid)
- WReg_pype2  in  5  destination register
- RegWrite_pype2  in  1  register write enable
- MemtoReg_pype2  in  2  writeback source select, passed through
- MemRW_pype2  in  2  00 none, 01 load, 10 store, 11 treated as none
- PCp4_pype2  in  32  PC+4
- Instraction_pype2  in  32  instruction; funct3 = [14:12]; [13:12] gives size (00 B, 01 H, 10 W), [14] means unsigned load
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete, single-cycle pulse
- dmem_rdata  in  32  read word, valid when dmem_ack=1
- keep_mem  out  1  stall request to PC/IF/ID/EX (drives their keep inputs)
- mem_err  out  1  one-cycle pulse on misaligned access or timeout
- MemData_pype3, ALU_co_pype3, PCp4_pype3  out  32  MEM/WB register
- WReg_pype3  out  5
- RegWrite_pype3  out  1
- MemtoReg_pype3  out  2
- Instraction_pype3  out  32

Behaviour:
- Reset: all registered outputs 0, FSM to IDLE, dmem_req=0. Reset mid-access abandons the access; the ack that follows is ignored in IDLE.
- mem_op = (MemRW_pype2==01 or 10) and not misaligned and not nop.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE:
  - Non-memory op: MEM/WB loads the inputs on the next edge; MemData_pype3=0; no stall.
  - nop: MEM/WB loads a bubble (all fields 0).
  - Misaligned mem op: bubble, mem_err=1 for one cycle, no bus request.
  - Valid mem op: keep_mem=1 combinationally, MEM/WB loads a bubble, next state REQ.
- REQ:
  - dmem_req=1 (registered). Address, byte enables, wdata and we are held stable.
  - keep_mem = !dmem_ack.
  - On ack: a load captures its extracted data; MEM/WB loads the real instruction; next state IDLE.
  - Without ack: MEM/WB holds a bubble.
  - nop is ignored in REQ; the bus access cannot be cancelled.
- Latency: a memory op with ack on the first REQ cycle completes in 2 cycles. Non-memory ops take 1 cycle.
- Store byte enables and data:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{d[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{d[15:0]}}.
  - Word: be = 1111; wdata = d.
- Loads: be = 1111; sh = rdata >> (8*addr[1:0]).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: rdata.
- Size 11 is treated as a word access.
- Stores write MemData_pype3=0.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - A counter clears on entry to REQ.
  - If it reaches TIMEOUT_CYCLES without ack: drop dmem_req, mem_err pulse, MEM/WB bubble, return to IDLE, keep_mem deasserts.
- Undefined: no counter; REQ waits indefinitely.

Test Plan:
- Non-memory op: ADD result 0x0000_0005, rd=3 → one cycle later ALU_co_pype3=5, WReg_pype3=3, keep_mem never 1.
- LB, addr 0x103, ack on first REQ cycle, rdata 0x80AB_CDEF → MemData_pype3=0xFFFF_FF80, 2-cycle total, keep_mem high 1 cycle.
- LHU, addr 0x102, rdata 0x9234_5678, ack after 3 wait cycles → MemData_pype3=0x0000_9234; keep_mem high until the ack cycle; RegWrite_pype3=0 during the wait.
- SB, addr 0x201, data 0x0000_00A5 → dmem_we=1, dmem_be=0010, dmem_wdata=0xA5A5_A5A5, dmem_addr=0x200.
- Misaligned LW, addr 0x102 → mem_err pulses, dmem_req stays 0, RegWrite_pype3=0, no stall. Separately, rst low during REQ → dmem_req=0 immediately and outputs zero.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → dmem_req falls after 4 REQ cycles, mem_err=1, keep_mem=0.
